// File: rtl/bus_arb_pkg.sv
// Shared types for the two-cache system bus arbiter.
// Holds the FSM state, the owner encoding and the tag bit that marks a read.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int READ_BIT = 12;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the cache-side and system-bus-side signals around the arbiter.
// Handshake: a beat moves in a cycle where its cyc and its ack are both high; ack may depend combinationally on cyc.
interface bus_arbiter_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);

  logic                      i_bid;
  logic                      d_bid;
  logic                      i_grant;
  logic                      d_grant;
  logic                      i_reqcyc;
  logic                      d_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] i_req;
  logic [BUS_DATA_WIDTH-1:0] d_req;
  logic [BUS_TAG_WIDTH-1:0]  i_reqtag;
  logic [BUS_TAG_WIDTH-1:0]  d_reqtag;
  logic                      i_reqack;
  logic                      d_reqack;
  logic                      i_respcyc;
  logic                      d_respcyc;
  logic                      i_respack;
  logic                      d_respack;
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic                      bus_respack;

  // Arbiter side.
  modport slave (
    input  i_bid, d_bid, i_reqcyc, d_reqcyc, i_req, d_req, i_reqtag, d_reqtag,
    input  i_respack, d_respack, bus_reqack, bus_respcyc,
    output i_grant, d_grant, i_reqack, d_reqack, i_respcyc, d_respcyc,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  // Caches plus system bus, as seen by whoever drives the arbiter.
  modport master (
    output i_bid, d_bid, i_reqcyc, d_reqcyc, i_req, d_req, i_reqtag, d_reqtag,
    output i_respack, d_respack, bus_reqack, bus_respcyc,
    input  i_grant, d_grant, i_reqack, d_reqack, i_respcyc, d_respcyc,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

endinterface

// File: rtl/bus_arb_rr.sv
// Two-way round-robin picker: a lone bidder wins; on a tie the cache that
// did not own the bus last wins.
module bus_arb_rr
  import bus_arb_pkg::*;
(
  input  logic   i_bid,
  input  logic   d_bid,
  input  owner_t last_owner,
  output owner_t winner,
  output logic   valid
);

  always_comb begin
    valid  = i_bid | d_bid;
    winner = OWN_I;
    if (i_bid && d_bid) begin
      winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (d_bid) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the instruction and data caches onto one system bus, one line
// transaction at a time, and muxes request/response handshakes to the owner.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus,
  output logic         err,
  output state_t       state_dbg
);

  localparam int CW = $clog2(BEATS) + 1;

  state_t  state_q, state_d;
  owner_t  owner_q, owner_d;
  owner_t  last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic    err_q, err_d;

  owner_t  win;
  logic    win_valid;

  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;
  logic                      active;
  logic                      in_resp;
  logic                      req_beat;
  logic                      resp_beat;
  logic                      last_beat;

  bus_arb_rr u_rr (
    .i_bid      (bus.i_bid),
    .d_bid      (bus.d_bid),
    .last_owner (last_q),
    .winner     (win),
    .valid      (win_valid)
  );

  assign own_reqcyc  = (owner_q == OWN_I) ? bus.i_reqcyc  : bus.d_reqcyc;
  assign own_req     = (owner_q == OWN_I) ? bus.i_req     : bus.d_req;
  assign own_reqtag  = (owner_q == OWN_I) ? bus.i_reqtag  : bus.d_reqtag;
  assign own_respack = (owner_q == OWN_I) ? bus.i_respack : bus.d_respack;

  assign active    = (state_q != ST_IDLE);
  assign in_resp   = (state_q == ST_RESP);
  assign req_beat  = (state_q == ST_REQ) && own_reqcyc && bus.bus_reqack;
  assign resp_beat = in_resp && bus.bus_respcyc && own_respack;
  assign last_beat = (cnt_q == CW'(BEATS - 1));

  // Everything toward the non-owner stays low; IDLE drives nothing.
  always_comb begin
    bus.i_grant     = 1'b0;
    bus.d_grant     = 1'b0;
    bus.i_reqack    = 1'b0;
    bus.d_reqack    = 1'b0;
    bus.i_respcyc   = 1'b0;
    bus.d_respcyc   = 1'b0;
    bus.bus_reqcyc  = 1'b0;
    bus.bus_req     = '0;
    bus.bus_reqtag  = '0;
    bus.bus_respack = 1'b0;
    if (active) begin
      bus.bus_reqcyc = own_reqcyc;
      bus.bus_req    = own_req;
      bus.bus_reqtag = own_reqtag;
      if (owner_q == OWN_I) begin
        bus.i_grant  = 1'b1;
        bus.i_reqack = bus.bus_reqack;
      end else begin
        bus.d_grant  = 1'b1;
        bus.d_reqack = bus.bus_reqack;
      end
    end
    if (in_resp) begin
      bus.bus_respack = own_respack;
      if (owner_q == OWN_I) bus.i_respcyc = bus.bus_respcyc;
      else                  bus.d_respcyc = bus.bus_respcyc;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    // A response beat with no read in its response phase is a protocol error.
    err_d   = err_q | (bus.bus_respcyc & ~in_resp);
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_REQ;
          owner_d = win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (req_beat) begin
          if (own_reqtag[READ_BIT]) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RESP: begin
        if (resp_beat) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_D;
      last_q  <= OWN_D;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
